// File: rtl/fifo.sv
// fifo: single-clock FIFO whose pointers carry an extra wrap bit to tell full from empty
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_wen,
    output logic             o_full,
    output logic [WIDTH-1:0] o_rdata,
    input  logic             i_ren,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic we, re;
    assign we = i_wen && !o_full;
    assign re = i_ren && !o_empty;
    assign o_empty = wptr == rptr;
    assign o_full = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    always_ff @(posedge i_clk)
        if (we) mem[wptr[AW-1:0]] <= i_wdata;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            wptr <= '0;
            rptr <= '0;
            o_rdata <= '0;
        end else begin
            if (we) wptr <= wptr + 1'b1;
            if (re) begin
                o_rdata <= mem[rptr[AW-1:0]];
                rptr <= rptr + 1'b1;
            end
        end
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: random and directed stimulus against a queue-based FIFO model
module tb_fifo;
    localparam int W = 4;
    localparam int D = 8;
    logic i_clk = 0, i_rst = 1, i_wen = 0, i_ren = 0;
    logic [W-1:0] i_wdata = '0;
    logic o_full, o_empty;
    logic [W-1:0] o_rdata;
    logic [W-1:0] q[$];
    logic [W-1:0] exp_rd = '0;
    int errors = 0, checks = 0;

    fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_wdata(i_wdata), .i_wen(i_wen),
        .o_full(o_full), .o_rdata(o_rdata), .i_ren(i_ren), .o_empty(o_empty)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".empty"}, o_empty, q.size() == 0);
        chk({tag, ".full"}, o_full, q.size() == D);
        chk({tag, ".rdata"}, o_rdata, exp_rd);
    endtask

    task automatic step(input string tag, input logic w, input logic r, input logic [W-1:0] d);
        bit aw, ar;
        i_wen = w;
        i_ren = r;
        i_wdata = d;
        @(posedge i_clk);
        aw = w && q.size() != D;
        ar = r && q.size() != 0;
        if (ar) exp_rd = q.pop_front();
        if (aw) q.push_back(d);
        @(negedge i_clk);
        chk_all(tag);
    endtask

    initial begin
        i_wen = 1;
        i_ren = 1;
        i_wdata = 4'h5;
        repeat (3) begin
            @(negedge i_clk);
            chk_all("reset");
        end
        i_rst = 0;
        i_wen = 0;
        i_ren = 0;
        @(negedge i_clk);
        chk_all("post_reset");
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < D; i++) step("fill", 1, 0, W'((i + p * 8) % 16));
            step("overflow", 1, 0, 4'hF);
            for (int i = 0; i < D; i++) step("drain", 0, 1, 4'h0);
            step("underflow", 0, 1, 4'h0);
        end
        for (int i = 0; i < 4; i++) step("pre_sim", 1, 0, W'(i + 3));
        for (int i = 0; i < 10; i++) step("sim4", 1, 1, W'($urandom));
        chk("occ4", q.size(), 4);
        for (int i = 0; i < 4; i++) step("top_up", 1, 0, W'($urandom));
        step("sim_full", 1, 1, 4'hE);
        for (int i = 0; i < 7; i++) step("empty_out", 0, 1, 4'h0);
        step("sim_empty", 1, 1, 4'h9);
        for (int i = 0; i < 4; i++) step("pre_rst", 1, 0, W'(i + 1));
        @(negedge i_clk);
        #1 i_rst = 1;
        #1;
        q.delete();
        exp_rd = '0;
        chk_all("async_rst");
        #1 i_rst = 0;
        step("rst_w", 1, 0, 4'hA);
        step("rst_r", 0, 1, 4'h0);
        chk("rst_readback", o_rdata, 4'hA);
        for (int ph = 0; ph < 6; ph++) begin
            int pw, pr;
            pw = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 15 : 50;
            pr = (ph % 3 == 0) ? 15 : (ph % 3 == 1) ? 85 : 50;
            for (int i = 0; i < 100; i++)
                step("rand", $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, W'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
